imem_dmem_arbiter: RTL
======================

Name: imem_dmem_arbiter

Overview:
- Shares one 128-bit-block main memory between the instruction cache miss path and the data cache miss/write-back path.
- Sits between the two cache controllers and the memory model.
- Presents each cache with its own read/busywait interface and serialises their block transfers with round-robin priority.
- Maps each requester into its own memory region and watches for a hung memory.

Parameters:
- ADDR_W, 6, block address width from each cache.
- DATA_W, 128, block width.
- TIMEOUT, 255, maximum cycles a granted transfer may wait on mem_busywait before an error is flagged.
- I_REGION, 1'b0, region bit prepended to instruction addresses; data uses ~I_REGION.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- imem_read  in  1  instruction cache block-read request.
- imem_address  in  ADDR_W  instruction block address.
- imem_busywait  out  1  stall to instruction cache.
- mem_instruction  out  DATA_W  block returned to instruction cache.
- dmem_read  in  1  data cache block-read request.
- dmem_write  in  1  data cache block-write request.
- dmem_address  in  ADDR_W  data block address.
- dmem_writedata  in  DATA_W  block to write.
- dmem_busywait  out  1  stall to data cache.
- dmem_readdata  out  DATA_W  block returned to data cache.
- mem_read  out  1  shared memory read strobe.
- mem_write  out  1  shared memory write strobe.
- mem_address  out  ADDR_W+1  {region, block address}.
- mem_writedata  out  DATA_W  write block.
- mem_readdata  in  DATA_W  memory read block.
- mem_busywait  in  1  memory busy.
- arb_error  out  1  sticky timeout flag.

Behaviour:
- Reset (reset=0, asynchronous): all of the following take effect immediately and any in-flight memory request is dropped.
  - State is IDLE.
  - mem_read=0, mem_write=0, mem_address=0, mem_writedata=0.
  - mem_instruction=0, dmem_readdata=0, arb_error=0, timeout counter=0.
  - last_grant=D, so the instruction side wins the first tie.
- Request decode: req_i = imem_read; req_d = dmem_read | dmem_write. If dmem_read and dmem_write are both high, the request is treated as a write.
- Busywait (combinational): imem_busywait = req_i & ~done_i; dmem_busywait = req_d & ~done_d.
  - done_x is high only in DONE with grant=x.
  - A requester is therefore stalled in the same cycle its request rises.
- FSM states: IDLE, GRANT_I, GRANT_D, DONE.
- IDLE:
  - At the clock edge, if only one request is pending, grant it.
  - If both are pending, grant the side that is not last_grant.
  - Register mem_read/mem_write/mem_address/mem_writedata from the winner's inputs; load the counter with 0; update last_grant.
  - If no request is pending, remain in IDLE with strobes low.
- GRANT_x:
  - Strobes and address are held stable; requester inputs are ignored.
  - The counter increments each cycle.
  - At an edge where counter≥1 and mem_busywait=0:
    - For a read, capture mem_readdata into mem_instruction (I) or dmem_readdata (D).
    - Clear the strobes and go to DONE.
  - At an edge where the counter reaches TIMEOUT with mem_busywait=1:
    - Set arb_error=1 (sticky until reset).
    - Clear the strobes and go to DONE with the read data registers unchanged.
- DONE:
  - Exactly one cycle; the granted side's busywait is low for that cycle.
  - Always returns to IDLE.
  - The requester is expected to drop its request in this cycle. If it does not, it re-enters arbitration from IDLE as a new request.
- Minimum latency: request rises → busywait low = 2 cycles plus memory busy time. Back-to-back grants are separated by at least one IDLE cycle.
- A request withdrawn mid-grant does not abort the transfer; it completes normally.
- Read data registers hold their value until that side's next read completes. A data-side write never alters dmem_readdata.
- mem_address = {I_REGION, imem_address} for I grants and {~I_REGION, dmem_address} for D grants.

Decomposition:
- Shared package arb_pkg:
  - FSM state encoding (2-bit).
  - GRANT_I/GRANT_D encodings.
  - Region constants.
- One sub-module rr_pick2: two-request round-robin picker (inputs req_i, req_d, last_grant; outputs grant_valid, grant_sel). It is purely combinational and instantiated once.

Test Plan:
- Reset: hold reset=0 mid-transfer with mem_read=1 → mem_read, mem_write, arb_error and both busywaits are 0 immediately; state IDLE after release.
- Lone I read:
  - Stimulus: imem_read=1, imem_address=6'h15; memory busy for 3 cycles, returning 128'hA5…A5.
  - Required response: mem_address=7'h15, mem_read=1; imem_busywait low for exactly one cycle; mem_instruction=128'hA5…A5.
- Simultaneous requests:
  - Stimulus: imem_read and dmem_read rise in the same cycle after reset.
  - Required response: I granted first, D granted after I's DONE plus one IDLE cycle with mem_address=7'h40|addr; dmem_busywait high throughout I's transfer.
- D write then I tie:
  - Stimulus: dmem_write with 128'h1234 is granted last, then both sides request together.
  - Required response: mem_writedata=128'h1234 with mem_write=1 during D's grant; at the tie I wins; dmem_readdata unchanged.
- Conflicting D strobes: dmem_read=dmem_write=1 → mem_write=1, mem_read=0.
- Timeout:
  - Stimulus: TIMEOUT=4, mem_busywait stuck at 1.
  - Required response: arb_error=1 after 4 grant cycles; busywait drops for one cycle; returns to IDLE; arb_error stays 1 until reset.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package arb_pkg;

  // Arbiter FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_DONE    = 2'd3
  } arb_state_t;

  // Which requester owns (or last owned) the memory
  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  // Region bit prepended to the instruction block address; data uses the complement
  localparam logic REGION_I_DEFAULT = 1'b0;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin picker: a tie goes to the side that was not granted last.
module rr_pick2
  import arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_t last_grant,
  output logic   grant_valid,
  output grant_t grant_sel
);

  // Lone request wins outright; a tie alternates against last_grant
  always_comb begin
    grant_valid = req_i | req_d;
    grant_sel   = GNT_I;
    if (req_i && req_d)
      grant_sel = (last_grant == GNT_D) ? GNT_I : GNT_D;
    else if (req_d)
      grant_sel = GNT_D;
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Serialises I-cache and D-cache block transfers onto one shared memory,
// with round-robin priority, per-requester address regions and a hang timeout.
module imem_dmem_arbiter
  import arb_pkg::*;
#(
  parameter int   ADDR_W   = 6,
  parameter int   DATA_W   = 128,
  parameter int   TIMEOUT  = 255,
  parameter logic I_REGION = REGION_I_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              imem_read,
  input  logic [ADDR_W-1:0] imem_address,
  output logic              imem_busywait,
  output logic [DATA_W-1:0] mem_instruction,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [ADDR_W-1:0] dmem_address,
  input  logic [DATA_W-1:0] dmem_writedata,
  output logic              dmem_busywait,
  output logic [DATA_W-1:0] dmem_readdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W:0]   mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait,
  output logic              arb_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t       state, state_nxt;
  grant_t           last_grant;     // also identifies the owner while in GRANT/DONE
  grant_t           pick_sel;
  logic             pick_vld;
  logic [CNT_W-1:0] cnt;
  logic             req_i, req_d, in_grant, xfer_ok, xfer_to;

  assign req_i = imem_read;
  assign req_d = dmem_read | dmem_write;

  rr_pick2 u_pick (
    .req_i       (req_i),
    .req_d       (req_d),
    .last_grant  (last_grant),
    .grant_valid (pick_vld),
    .grant_sel   (pick_sel)
  );

  // A transfer finishes once memory has had at least one cycle to raise busywait;
  // it is abandoned when the counter would reach TIMEOUT with memory still busy.
  assign in_grant = (state == ST_GRANT_I) || (state == ST_GRANT_D);
  assign xfer_ok  = in_grant && (cnt != '0) && !mem_busywait;
  assign xfer_to  = in_grant && mem_busywait && (cnt == CNT_W'(TIMEOUT - 1));

  // Stall each side until its own DONE cycle; reset releases both stalls at once
  assign imem_busywait = reset & req_i & ~((state == ST_DONE) && (last_grant == GNT_I));
  assign dmem_busywait = reset & req_d & ~((state == ST_DONE) && (last_grant == GNT_D));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (pick_vld) state_nxt = (pick_sel == GNT_I) ? ST_GRANT_I : ST_GRANT_D;
      ST_GRANT_I, ST_GRANT_D:
        if (xfer_ok || xfer_to) state_nxt = ST_DONE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // Memory request registers, read-data capture, timeout counter and error flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_writedata   <= '0;
      mem_instruction <= '0;
      dmem_readdata   <= '0;
      arb_error       <= 1'b0;
      cnt             <= '0;
      last_grant      <= GNT_D;
    end else begin
      case (state)
        ST_IDLE:
          if (pick_vld) begin
            cnt        <= '0;
            last_grant <= pick_sel;
            if (pick_sel == GNT_I) begin
              mem_read    <= 1'b1;
              mem_write   <= 1'b0;
              mem_address <= {I_REGION, imem_address};
            end else begin
              // read+write together is treated as a write
              mem_read      <= ~dmem_write;
              mem_write     <= dmem_write;
              mem_address   <= {~I_REGION, dmem_address};
              mem_writedata <= dmem_writedata;
            end
          end
        ST_GRANT_I, ST_GRANT_D: begin
          cnt <= cnt + 1'b1;
          if (xfer_ok || xfer_to) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
          if (xfer_ok && mem_read) begin
            if (state == ST_GRANT_I) mem_instruction <= mem_readdata;
            else                     dmem_readdata   <= mem_readdata;
          end
          if (xfer_to) arb_error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
